// File: rtl/sfgates_selftest_ctrl.sv
// ---------------------------------------------------------------------------
// sfgates_selftest_ctrl
//
// Self-test sequencer for a six-output two-input gates unit. A run applies
// the four input vectors {a,b} = 00, 01, 10, 11 in order. Each vector is
// held for SETTLE cycles (DRIVE) plus one compare cycle (CHECK). Every y
// bit is compared against its golden gate function, and any mismatches are
// collected per output bit (err_mask) and per vector (err_vec). A single
// DONE cycle closes the run: it pulses done and loads pass.
//
// Handshake: start is a level request. It is accepted only on a rising edge
// where the FSM is IDLE and abort is low, and it is never queued. abort
// cancels a run at the next edge from any non-IDLE state. When abort is
// high during the DONE cycle, it also masks that cycle's done pulse.
//
// Parameters
//   SETTLE    cycles a/b are held before y is sampled (1..15)
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start     request one self-test run
//   abort     synchronous cancel of a run in progress
//   y[5:0]    gates unit outputs, y[0]=y1 .. y[5]=y6
//   a, b      stimulus to the gates unit
//   busy      high whenever the FSM is not IDLE
//   done      one-cycle pulse at the end of a completed run
//   pass      result of the last completed run, held
//   err_mask  per-output-bit mismatch flags for the run
//   err_vec   per-vector mismatch flags for the run (index = {a,b})
//   fsm_state current FSM state (IDLE=0, DRIVE=1, CHECK=2, DONE=3)
// ---------------------------------------------------------------------------
module sfgates_selftest_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_mask,
    output logic [3:0] err_vec,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state, state_next;
    logic [1:0] idx, idx_next;
    logic [3:0] cnt, cnt_next;
    logic       pass_next;
    logic [5:0] err_mask_next;
    logic [3:0] err_vec_next;
    logic [5:0] expected;
    logic [5:0] mismatch;

    // Golden gate functions for the vector currently being applied.
    always_comb begin
        expected = {~(idx[1] ^ idx[0]), (idx[1] ^ idx[0]),
                    ~(idx[1] | idx[0]), ~(idx[1] & idx[0]),
                    (idx[1] | idx[0]),  (idx[1] & idx[0])};
        mismatch = y ^ expected;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 2'd0;
            cnt      <= 4'd0;
            pass     <= 1'b0;
            err_mask <= 6'd0;
            err_vec  <= 4'd0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            cnt      <= cnt_next;
            pass     <= pass_next;
            err_mask <= err_mask_next;
            err_vec  <= err_vec_next;
        end
    end

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        cnt_next      = cnt;
        pass_next     = pass;
        err_mask_next = err_mask;
        err_vec_next  = err_vec;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next    = DRIVE;
                    idx_next      = 2'd0;
                    cnt_next      = 4'd0;
                    err_mask_next = 6'd0;
                    err_vec_next  = 4'd0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_next = IDLE;
                    idx_next   = 2'd0;
                    cnt_next   = 4'd0;
                    pass_next  = 1'b0;
                end else begin
                    cnt_next = cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (abort) begin
                    // Results of the aborted compare are discarded; only
                    // vectors that fully completed remain in the flags.
                    state_next = IDLE;
                    idx_next   = 2'd0;
                    cnt_next   = 4'd0;
                    pass_next  = 1'b0;
                end else begin
                    err_mask_next = err_mask | mismatch;
                    if (|mismatch) begin
                        err_vec_next[idx] = 1'b1;
                    end
                    if (idx == 2'd3) begin
                        state_next = DONE;
                    end else begin
                        state_next = DRIVE;
                        idx_next   = idx + 2'd1;
                        cnt_next   = 4'd0;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                idx_next   = 2'd0;
                cnt_next   = 4'd0;
                // err_mask already includes the final CHECK result here.
                pass_next  = abort ? 1'b0 : (err_mask == 6'd0);
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stimulus is only applied while a vector is active; otherwise it is 00.
    assign a         = (state == DRIVE || state == CHECK) ? idx[1] : 1'b0;
    assign b         = (state == DRIVE || state == CHECK) ? idx[0] : 1'b0;
    assign busy      = (state != IDLE);
    // abort in the DONE cycle suppresses the pulse combinationally.
    assign done      = (state == DONE) && !abort;
    assign fsm_state = state;

endmodule

// File: tb/tb_sfgates_selftest_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for sfgates_selftest_ctrl (SETTLE=2).
// A behavioural gates unit drives y from a/b, and stuck5 forces y5 low.
// Inputs change on the falling edge, and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_sfgates_selftest_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [5:0] y;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] err_mask;
    logic [3:0] err_vec;
    logic [1:0] fsm_state;
    logic       stuck5;

    int tests_run;
    int tests_failed;

    sfgates_selftest_ctrl #(.SETTLE(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .y        (y),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_mask (err_mask),
        .err_vec  (err_vec),
        .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // gates unit under test
    always_comb begin
        y[0] = a & b;
        y[1] = a | b;
        y[2] = ~(a & b);
        y[3] = ~(a | b);
        y[4] = a ^ b;
        y[5] = ~(a ^ b);
        if (stuck5) y[4] = 1'b0;
    end

    // driver: one start pulse; returns at the falling edge after the accept edge
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // driver: count falling edges until done (cycle 1 = first after accept)
    task automatic wait_done(input int limit, output int cycles);
        cycles = 1;
        while (done !== 1'b1 && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({a, b, busy, done, pass, err_mask, err_vec} !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got a=%b b=%b busy=%b done=%b pass=%b mask=%b vec=%b want all 0",
                     a, b, busy, done, pass, err_mask, err_vec);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_good_unit();
        logic [1:0] want_ab;
        pulse_start();
        for (int n = 1; n <= 12; n++) begin
            want_ab = 2'((n - 1) / 3);
            tests_run++;
            if ({a, b} !== want_ab || busy !== 1'b1 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL good_seq cycle %0d got ab=%b busy=%b done=%b want ab=%b busy=1 done=0",
                         n, {a, b}, busy, done, want_ab);
            end
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL good_done_cycle13 got done=%b busy=%b want 1 1", done, busy);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1 || err_mask !== 6'b000000 || err_vec !== 4'b0000) begin
            tests_failed++;
            $display("FAIL good_result got done=%b busy=%b pass=%b mask=%b vec=%b want 0 0 1 000000 0000",
                     done, busy, pass, err_mask, err_vec);
        end
    endtask

    task automatic test_abort_mid_run();
        int dcount;
        stuck5 = 1'b1;
        pulse_start();
        // n=1 now; vector 2 DRIVE occupies cycles 7 and 8
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || a !== 1'b0 || b !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_idle got busy=%b a=%b b=%b done=%b pass=%b want 0 0 0 0 0",
                     busy, a, b, done, pass);
        end
        tests_run++;
        if (err_vec !== 4'b0010 || err_mask !== 6'b010000) begin
            tests_failed++;
            $display("FAIL abort_partial_err got vec=%b mask=%b want 0010 010000", err_vec, err_mask);
        end
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        tests_run++;
        if (dcount !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_done got %0d pulses want 0", dcount);
        end
        stuck5 = 1'b0;
    endtask

    task automatic test_stuck_fault();
        int cycles;
        stuck5 = 1'b1;
        pulse_start();
        wait_done(40, cycles);
        tests_run++;
        if (cycles !== 13) begin
            tests_failed++;
            $display("FAIL stuck_latency got %0d want 13", cycles);
        end
        @(negedge clk);
        tests_run++;
        if (pass !== 1'b0 || err_mask !== 6'b010000 || err_vec !== 4'b0110) begin
            tests_failed++;
            $display("FAIL stuck_result got pass=%b mask=%b vec=%b want 0 010000 0110", pass, err_mask, err_vec);
        end
        stuck5 = 1'b0;
    endtask

    task automatic test_idle_abort();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_abort_wins busy got %b want 0", busy);
        end
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || err_vec !== 4'b0110) begin
            tests_failed++;
            $display("FAIL idle_abort_hold got busy=%b vec=%b want 0 0110", busy, err_vec);
        end
    endtask

    task automatic test_start_while_busy();
        int dcount;
        int n;
        dcount = 0;
        n = 0;
        @(negedge clk);
        start = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done === 1'b1) dcount++;
        tests_run++;
        if (n !== 13 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_start_done got cycle=%0d busy=%b want 13 1", n, busy);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_fall got busy=%b done=%b want 0 0", busy, done);
        end
        start = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        tests_run++;
        if (dcount !== 1 || busy !== 1'b0 || pass !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_single_done got pulses=%0d busy=%b pass=%b want 1 0 1", dcount, busy, pass);
        end
    endtask

    task automatic test_async_reset();
        int cycles;
        int dcount;
        pulse_start();
        // cycle 3 is the CHECK of vector 0
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({a, b, busy, done, pass, err_mask, err_vec} !== 15'd0) begin
            tests_failed++;
            $display("FAIL async_reset got a=%b b=%b busy=%b done=%b pass=%b mask=%b vec=%b want all 0",
                     a, b, busy, done, pass, err_mask, err_vec);
        end
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dcount++;
        end
        tests_run++;
        if (dcount !== 0) begin
            tests_failed++;
            $display("FAIL async_no_resume got %0d active cycles want 0", dcount);
        end
        pulse_start();
        wait_done(40, cycles);
        @(negedge clk);
        tests_run++;
        if (cycles !== 13 || pass !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_rerun got cycle=%0d pass=%b want 13 1", cycles, pass);
        end
    endtask

    task automatic test_abort_vs_done();
        int cycles;
        pulse_start();
        // advance to the falling edge that opens the DONE cycle (cycle 13)
        repeat (11) @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_done_mask got done=%b busy=%b want 0 1", done, busy);
        end
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if (pass !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_done_result got pass=%b busy=%b done=%b want 0 0 0", pass, busy, done);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40, cycles);
        @(negedge clk);
        tests_run++;
        if (cycles !== 13 || pass !== 1'b1 || err_mask !== 6'd0) begin
            tests_failed++;
            $display("FAIL abort_done_restart got cycle=%0d pass=%b mask=%b want 13 1 000000",
                     cycles, pass, err_mask);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        stuck5 = 1'b0;
        #2;
        test_reset();
        test_good_unit();
        test_abort_mid_run();
        test_stuck_fault();
        test_idle_abort();
        test_start_while_busy();
        test_async_reset();
        test_abort_vs_done();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
